// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC select codes,
// opcode constants, bubble encoding, FSM state encoding and the IF/ID slot type.
package if_fetch_stage_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b011;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // addi x0,x0,0
    localparam logic [31:0] INST_NOP = {12'd0, 5'd0, 3'b000, 5'd0, OPCODE_OP_IMM};

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_fetch_stage_npc_gen.sv
// Combinational next-PC target mux for the fetch stage.
module if_fetch_stage_npc_gen
    import if_fetch_stage_pkg::*;
(
    input  logic [2:0]  npc_op_i,
    input  logic [31:0] npc_imm_i,
    input  logic [31:0] pc_if_i,
    input  logic [31:0] pc_id_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] alu_result_ex_i,
    output logic [31:0] target_o
);

    // JAL resolves in decode, so its base is the IF/ID PC rather than EX.
    always_comb begin
        target_o = pc_if_i + 32'd4;
        case (npc_op_i)
            NPC_BRANCH: target_o = pc_ex_i + npc_imm_i;
            NPC_JUMP:   target_o = pc_id_i + npc_imm_i;
            NPC_JALR:   target_o = alu_result_ex_i & ~32'h1;
            default:    target_o = pc_if_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC register, imem request FSM (FETCH/HOLD/DRAIN) and IF/ID register.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IF,
    input  logic        flush_IF,
    input  logic [2:0]  NPCOp_in,
    input  logic [31:0] NPCImm_in,
    input  logic [31:0] pc_EX,
    input  logic [31:0] alu_result_EX,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_IF,
    output logic [31:0] inst_ID,
    output logic [31:0] pc_ID,
    output logic        valid_ID
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed,
    output logic [31:0] perf_wait
`endif
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    ifid_t       ifid_q, ifid_d;
    ifid_t       bubble;
    logic        redirect;
    logic [31:0] target;

    if_fetch_stage_npc_gen u_npc_gen (
        .npc_op_i        (NPCOp_in),
        .npc_imm_i       (NPCImm_in),
        .pc_if_i         (pc_q),
        .pc_id_i         (ifid_q.pc),
        .pc_ex_i         (pc_EX),
        .alu_result_ex_i (alu_result_EX),
        .target_o        (target)
    );

    assign redirect  = flush_IF & ~stall_IF;
    // Gating with rst_n drops the request the instant reset asserts.
    assign imem_req  = rst_n & (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : req_addr_q;

    assign pc_IF    = pc_q;
    assign inst_ID  = ifid_q.inst;
    assign pc_ID    = ifid_q.pc;
    assign valid_ID = ifid_q.valid;

    assign bubble = '{inst: NOP_INST, pc: pc_q, valid: 1'b0};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        drain_addr_d = drain_addr_q;
        inst_buf_d   = inst_buf_q;
        ifid_d       = ifid_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    ifid_d       = bubble;
                    pc_d         = target;
                    req_addr_d   = target;
                    drain_addr_d = req_addr_q;
                    state_d      = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack && !stall_IF) begin
                    ifid_d     = '{inst: imem_rdata, pc: pc_q, valid: 1'b1};
                    pc_d       = pc_q + 32'd4;
                    req_addr_d = pc_q + 32'd4;
                end else if (imem_ack) begin
                    inst_buf_d = imem_rdata;
                    state_d    = ST_HOLD;
                end else if (!stall_IF) begin
                    ifid_d = bubble;
                end
            end

            ST_HOLD: begin
                if (!stall_IF) begin
                    ifid_d     = '{inst: inst_buf_q, pc: pc_q, valid: 1'b1};
                    pc_d       = pc_q + 32'd4;
                    req_addr_d = pc_q + 32'd4;
                    state_d    = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // The abandoned fetch must complete before the new address goes out.
                if (!stall_IF) begin
                    ifid_d = bubble;
                end
                if (redirect) begin
                    pc_d       = target;
                    req_addr_d = target;
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
            inst_buf_q   <= 32'd0;
            ifid_q       <= '{inst: NOP_INST, pc: 32'd0, valid: 1'b0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            drain_addr_q <= drain_addr_d;
            inst_buf_q   <= inst_buf_d;
            ifid_q       <= ifid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_squashed_q, perf_wait_q;
    logic        fetch_load;

    assign fetch_load = ((state_q == ST_FETCH) & imem_ack & ~stall_IF & ~redirect)
                      | ((state_q == ST_HOLD) & ~stall_IF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q  <= 32'd0;
            perf_squashed_q <= 32'd0;
            perf_wait_q     <= 32'd0;
        end else begin
            if (fetch_load) perf_fetched_q <= sat_inc32(perf_fetched_q);
            if (redirect)   perf_squashed_q <= sat_inc32(perf_squashed_q);
            if ((state_q != ST_HOLD) && !imem_ack) perf_wait_q <= sat_inc32(perf_wait_q);
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
    assign perf_wait     = perf_wait_q;
`endif

    a_no_plus4_flush: assert property (@(posedge clk) disable iff (!rst_n)
        flush_IF |-> (NPCOp_in != NPC_PLUS4));

    a_no_redirect_from_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == ST_HOLD) && !stall_IF) |-> !flush_IF);

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req && !imem_ack) |=> $stable(imem_addr));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with a behavioural variable-latency imem.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_IF, flush_IF;
    logic [2:0]  NPCOp_in;
    logic [31:0] NPCImm_in, pc_EX, alu_result_EX;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_IF, inst_ID, pc_ID;
    logic        valid_ID;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_lat;
    logic [31:0] wait_cnt;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_IF      (stall_IF),
        .flush_IF      (flush_IF),
        .NPCOp_in      (NPCOp_in),
        .NPCImm_in     (NPCImm_in),
        .pc_EX         (pc_EX),
        .alu_result_EX (alu_result_EX),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_IF         (pc_IF),
        .inst_ID       (inst_ID),
        .pc_ID         (pc_ID),
        .valid_ID      (valid_ID)
    );

    // Memory acks after mem_lat waiting cycles; data is address + 0x100.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wait_cnt <= 32'd0;
        else if (!imem_req || imem_ack) wait_cnt <= 32'd0;
        else                            wait_cnt <= wait_cnt + 32'd1;
    end
    assign imem_ack   = imem_req && (wait_cnt == mem_lat);
    assign imem_rdata = imem_addr + 32'h100;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [2:0] op, input logic [31:0] imm,
                         input logic [31:0] pcex, input logic [31:0] alu);
        flush_IF      = 1'b1;
        NPCOp_in      = op;
        NPCImm_in     = imm;
        pc_EX         = pcex;
        alu_result_EX = alu;
    endtask

    task automatic noredir();
        flush_IF = 1'b0;
        NPCOp_in = NPC_PLUS4;
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc, input logic vld);
        chk({tag, "_inst"},  inst_ID,  inst);
        chk({tag, "_pc"},    pc_ID,    pc);
        chk({tag, "_valid"}, {31'd0, valid_ID}, {31'd0, vld});
    endtask

    initial begin
        rst_n = 1'b0; stall_IF = 1'b0; flush_IF = 1'b0; NPCOp_in = NPC_PLUS4;
        NPCImm_in = 32'd0; pc_EX = 32'd0; alu_result_EX = 32'd0; mem_lat = 32'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_pc_IF", pc_IF, 32'h0);
        chk_slot("rst", 32'h13, 32'h0, 1'b0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        // Zero-wait streaming
        rst_n = 1'b1;
        #1;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        tick();
        chk_slot("t1_c1", 32'h100, 32'h0, 1'b1);
        chk("t1_addr4", imem_addr, 32'h4);
        tick();
        chk_slot("t1_c2", 32'h104, 32'h4, 1'b1);
        chk("t1_pc8", pc_IF, 32'h8);

        // Stall at pc 0x8 for two cycles
        stall_IF = 1'b1;
        tick();
        chk("t2_s1_pc", pc_IF, 32'h8);
        chk_slot("t2_s1", 32'h104, 32'h4, 1'b1);
        chk("t2_s1_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("t2_s2_pc", pc_IF, 32'h8);
        chk_slot("t2_s2", 32'h104, 32'h4, 1'b1);
        stall_IF = 1'b0;
        tick();
        chk_slot("t2_rel", 32'h108, 32'h8, 1'b1);
        chk("t2_rel_pc", pc_IF, 32'hC);
        chk("t2_rel_addr", imem_addr, 32'hC);

        // Branch: 0x10 + 0x20
        redir(NPC_BRANCH, 32'h20, 32'h10, 32'h0);
        tick();
        chk("t3_pc", pc_IF, 32'h30);
        chk_slot("t3", 32'h13, 32'hC, 1'b0);
        chk("t3_addr", imem_addr, 32'h30);
        noredir();
        tick();
        chk_slot("t3_next", 32'h130, 32'h30, 1'b1);

        // JAL: base is pc_ID (0x30), not pc_IF (0x34)
        redir(NPC_JUMP, 32'h100, 32'h0, 32'h0);
        tick();
        chk("jal_pc", pc_IF, 32'h130);
        noredir();
        tick();
        chk_slot("jal_next", 32'h230, 32'h130, 1'b1);

        // JALR clears bit 0
        redir(NPC_JALR, 32'h0, 32'h0, 32'h45);
        tick();
        chk("t4_pc", pc_IF, 32'h44);
        noredir();
        tick();
        chk_slot("t4_next", 32'h144, 32'h44, 1'b1);

        // Wrap from 0xFFFF_FFFC to 0
        redir(NPC_JALR, 32'h0, 32'h0, 32'hFFFF_FFFD);
        tick();
        chk("wrap_pc", pc_IF, 32'hFFFF_FFFC);
        noredir();
        tick();
        chk_slot("wrap_next", 32'h0000_00FC, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_pc0", pc_IF, 32'h0);

        // Three-cycle memory, redirect in the first wait cycle
        mem_lat = 32'd2;
        redir(NPC_BRANCH, 32'h100, 32'h100, 32'h0);
        tick();
        chk("t5_pc", pc_IF, 32'h200);
        chk("t5_d1_addr", imem_addr, 32'h0);
        chk("t5_d1_valid", {31'd0, valid_ID}, 32'd0);
        noredir();
        tick();
        chk("t5_d2_addr", imem_addr, 32'h0);
        chk("t5_d2_valid", {31'd0, valid_ID}, 32'd0);
        tick();
        chk("t5_f_addr", imem_addr, 32'h200);
        chk_slot("t5_f", 32'h13, 32'h200, 1'b0);
        tick();
        chk("t5_w1_valid", {31'd0, valid_ID}, 32'd0);
        chk("t5_w1_addr", imem_addr, 32'h200);
        tick();
        chk("t5_w2_valid", {31'd0, valid_ID}, 32'd0);
        tick();
        chk_slot("t5_got", 32'h300, 32'h200, 1'b1);
        chk("t5_pc_next", pc_IF, 32'h204);

        // Reset pulsed mid-drain
        redir(NPC_BRANCH, 32'h200, 32'h200, 32'h0);
        tick();
        chk("t6_drain_addr", imem_addr, 32'h204);
        chk("t6_drain_pc", pc_IF, 32'h400);
        noredir();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pc", pc_IF, 32'h0);
        chk_slot("t6_rst", 32'h13, 32'h0, 1'b0);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        mem_lat = 32'd0;
        rst_n = 1'b1;
        #1;
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk_slot("t6_first", 32'h100, 32'h0, 1'b1);
        chk("t6_pc", pc_IF, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Fetch stage of the 5-stage pipeline. It owns the PC register, the next-PC mux driven by the hazard unit's NPCOp/NPCImm decision, the instruction-memory request handshake and the IF/ID pipeline register. It consumes stall_IF, flush_IF, NPCOp and NPCImm from hazard detection, and feeds instruction and PC to the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) written into IF/ID on flush or empty slot.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_IF  in  1  hold PC and IF/ID (load-use).
flush_IF  in  1  squash the instruction being fetched; redirect the PC.
NPCOp_in  in  3  next-PC select: NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JALR.
NPCImm_in  in  32  branch or JAL offset.
pc_EX  in  32  PC of the EX-stage instruction (branch base).
alu_result_EX  in  32  JALR target, before bit-0 clear.
imem_req  out  1  instruction fetch request.
imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
imem_ack  in  1  fetch complete; imem_rdata valid this cycle. Ack in the same cycle as req is allowed.
imem_rdata  in  32  fetched instruction.
pc_IF  out  32  current architectural fetch PC.
inst_ID  out  32  IF/ID instruction.
pc_ID  out  32  IF/ID PC.
valid_ID  out  1  IF/ID slot holds a real instruction.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc_IF=RESET_PC, inst_ID=NOP_INST, pc_ID=0, valid_ID=0.
  - State = FETCH. req_addr_q=RESET_PC. inst_buf=0.
  - imem_req is combinational from state and deasserts as soon as reset is asserted.
  - Reset asserted mid-request abandons the outstanding request. The memory must tolerate this.
- Redirect targets:
  - NPC_BRANCH: pc_EX+NPCImm_in.
  - NPC_JUMP: pc_ID+NPCImm_in. The JAL base is this block's own IF/ID PC.
  - NPC_JALR: alu_result_EX & ~32'h1.
  - NPC_PLUS4: pc_IF+4.
  - All arithmetic is 32-bit modulo; wrap at 0xFFFF_FFFC→0 is silent.
- redirect = flush_IF & ~stall_IF. stall_IF has priority: flush_IF is ignored while stalled.
- flush_IF with NPC_PLUS4 is illegal and is covered by an assertion.
- State FETCH: imem_req=1, imem_addr=req_addr_q (equals pc_IF).
  - ack & ~stall & ~redirect: IF/ID←{imem_rdata, pc_IF, 1}; pc_IF, req_addr_q←pc_IF+4. With zero-wait memory this gives 1 instruction/cycle.
  - ack & stall: inst_buf←imem_rdata; IF/ID holds; go HOLD.
  - redirect (any ack): IF/ID←{NOP_INST, pc_IF, 0}; pc_IF, req_addr_q←target. If ack, stay FETCH; else go DRAIN.
  - ~ack & ~stall & ~redirect: IF/ID←bubble (valid 0); stay FETCH.
  - ~ack & stall: IF/ID holds.
- State HOLD: imem_req=0.
  - stall: hold everything.
  - ~stall & redirect cannot occur (the buffered instruction precedes any redirect source); it is covered by an assertion.
  - ~stall: IF/ID←{inst_buf, pc_IF, 1}; pc_IF, req_addr_q←pc_IF+4; go FETCH.
- State DRAIN: imem_req=1, imem_addr=old address held in a separate drain_addr_q, loaded at redirect.
  - Returned data is discarded. IF/ID gets a bubble unless stall.
  - On ack, go FETCH at the new pc_IF.
  - A further redirect in DRAIN overwrites pc_IF only; the drain continues.
- Latency: the instruction appears on inst_ID the cycle after ack. A redirect costs at least 1 bubble, plus the remaining drain cycles.

Optional Feature:
Macro: IF_PERF_CNT_EN.
- With the macro defined, the block adds outputs perf_fetched[31:0], perf_squashed[31:0] and perf_wait[31:0]:
  - perf_fetched counts IF/ID loads with valid=1.
  - perf_squashed counts redirects.
  - perf_wait counts FETCH/DRAIN cycles without ack.
- The counters reset to 0, saturate at 32'hFFFF_FFFF and do not count while rst_n=0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header: NPC_PLUS4=3'b000, NPC_BRANCH=3'b001, NPC_JUMP=3'b010, NPC_JALR=3'b011; OPCODE_* defines; NOP encoding; state encoding FETCH/HOLD/DRAIN.
- One sub-module: npc_gen, a combinational target mux taking NPCOp, NPCImm, pc_IF, pc_ID, pc_EX and alu_result_EX, and producing the target.
- The FSM and the IF/ID register stay in the top module.

Test Plan:
1. Reset release, zero-wait memory returns addr+0x100: imem_addr 0,4,8,… each cycle; inst_ID=0x100,0x104,… one cycle later; valid_ID=1.
2. stall_IF high 2 cycles at pc_IF=0x8: pc_IF holds 0x8; inst_ID holds; state goes HOLD; after release, the buffered inst appears with pc_ID=0x8 and no refetch.
3. Branch: NPCOp=BRANCH, flush_IF, pc_EX=0x10, imm=0x20. Next cycle pc_IF=0x30; inst_ID=0x13, valid_ID=0.
4. JALR with alu_result_EX=0x45: pc_IF=0x44, bit 0 cleared.
5. Memory with 3-cycle ack, redirect to 0x200 in the first wait cycle: imem_addr stays at the old address until ack; the returned data is discarded; next request goes to 0x200; valid_ID=0 throughout the drain.
6. rst_n pulsed low mid-DRAIN: outputs return immediately to reset values; the next fetch is at RESET_PC.
